// File: rtl/mannix_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mannix_mem_pkg
// Purpose : Shared types and helpers for the mannix memory bank responder.
// Revision: 1.0 - initial release
// ============================================================================
package mannix_mem_pkg;

  // Bank life cycle: zero-fill after reset, then serve requests
  typedef enum logic [0:0] {
    INIT = 1'b0,
    IDLE = 1'b1
  } bank_state_e;

  // Initiator side, used for round-robin bookkeeping
  typedef enum logic [0:0] {
    RD = 1'b0,
    WR = 1'b1
  } arb_side_e;

  // One parity bit per data byte
  function automatic int PARITY_W(input int data_width);
    return data_width / 8;
  endfunction

endpackage : mannix_mem_pkg
`default_nettype wire

// File: rtl/mannix_bank_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mannix_bank_rd_pipe
// Purpose : Fixed-depth read return pipeline (valid/data/err). Stage 0 captures
//           the array read at the grant edge; the last stage drives the port.
//           Data stages load only on a valid beat so the output holds.
// Revision: 1.0 - initial release
// ============================================================================
module mannix_bank_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  err_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  err_o
);

  logic [RD_LATENCY-1:0] valid_q;
  logic [RD_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];

  // Shift beats toward the output; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      err_q[0]   <= err_i & valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q[RD_LATENCY-1];
  assign err_o   = err_q[RD_LATENCY-1];
  assign data_o  = data_q[RD_LATENCY-1];

endmodule : mannix_bank_rd_pipe
`default_nettype wire

// File: rtl/mannix_mem_bank_rsp.sv
`default_nettype none
// ============================================================================
// Module  : mannix_mem_bank_rsp
// Purpose : Single SRAM bank responder for one read and one write initiator.
//           Zero-fills after reset, round-robin arbitrates contested cycles,
//           commits byte-enabled writes, returns reads at RD_LATENCY.
//           Optional feature macro: MANNIX_BANK_PARITY_EN (per-byte even
//           parity stored with data, mismatch reported on rd_err_o).
// Revision: 1.0 - initial release
// ============================================================================
module mannix_mem_bank_rsp
  import mannix_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int BANK_ADDR_WIDTH = 10,
  parameter int RD_LATENCY      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_req_i,
  input  logic [BANK_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                       rd_gnt_o,
  output logic                       rd_valid_o,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  input  logic                       wr_req_i,
  input  logic [BANK_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]    wr_be_i,
  output logic                       wr_gnt_o,
  output logic                       init_done_o,
  output logic                       rd_err_o
);

  localparam int DEPTH = 1 << BANK_ADDR_WIDTH;
  localparam int NB    = PARITY_W(DATA_WIDTH);

  bank_state_e                state_q;
  arb_side_e                  last_winner_q;
  logic [BANK_ADDR_WIDTH-1:0] init_cnt_q;
  logic                       init_done_q;

  logic [DATA_WIDTH-1:0]      mem_q [DEPTH];

  logic w_serving;
  logic w_rd_gnt;
  logic w_wr_gnt;
  logic w_rd_err_in;

  // Grants never assert while in reset or zero-filling; on contest the side
  // that did not win last time gets the bank
  assign w_serving = rst_n && (state_q == IDLE);
  assign w_rd_gnt  = w_serving && rd_req_i && (!wr_req_i || (last_winner_q == WR));
  assign w_wr_gnt  = w_serving && wr_req_i && (!rd_req_i || (last_winner_q == RD));

  assign rd_gnt_o    = w_rd_gnt;
  assign wr_gnt_o    = w_wr_gnt;
  assign init_done_o = init_done_q;

  // Bank state machine: zero-fill sweep, then round-robin bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      last_winner_q <= WR;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == '1) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (rd_req_i && wr_req_i) begin
            last_winner_q <= w_rd_gnt ? RD : WR;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

`ifdef MANNIX_BANK_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] w_rd_par;

  // Recompute even parity of the addressed word for comparison
  always_comb begin
    w_rd_par = '0;
    for (int b = 0; b < NB; b++) begin
      w_rd_par[b] = ^mem_q[rd_addr_i][8*b +: 8];
    end
  end

  assign w_rd_err_in = |(w_rd_par ^ par_q[rd_addr_i]);

  // Parity array follows the data array write pattern
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      par_q[init_cnt_q] <= '0;
    end else if (w_wr_gnt) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) begin
          par_q[wr_addr_i][b] <= ^wr_data_i[8*b +: 8];
        end
      end
    end
  end
`else
  assign w_rd_err_in = 1'b0;
`endif

  // Data array: zero-fill sweep during INIT, byte-enabled commits when served
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[init_cnt_q] <= '0;
    end else if (w_wr_gnt) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be_i[b]) begin
          mem_q[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
      end
    end
  end

  mannix_bank_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (w_rd_gnt),
    .data_i  (mem_q[rd_addr_i]),
    .err_i   (w_rd_err_in),
    .valid_o (rd_valid_o),
    .data_o  (rd_data_o),
    .err_o   (rd_err_o)
  );

endmodule : mannix_mem_bank_rsp
`default_nettype wire

// File: tb/tb_mannix_mem_bank_rsp.sv
`default_nettype none
// ============================================================================
// Module  : tb_mannix_mem_bank_rsp
// Purpose : Directed self-checking bench for mannix_mem_bank_rsp.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mannix_mem_bank_rsp;

  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int RDL   = 2;
  localparam int TMO   = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW/8-1:0] wr_be;
  logic          wr_gnt;
  logic          init_done;
  logic          rd_err;

  int checks = 0;
  int errors = 0;

  mannix_mem_bank_rsp #(
    .DATA_WIDTH      (DW),
    .BANK_ADDR_WIDTH (AW),
    .RD_LATENCY      (RDL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .rd_gnt_o    (rd_gnt),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data),
    .wr_req_i    (wr_req),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_be_i     (wr_be),
    .wr_gnt_o    (wr_gnt),
    .init_done_o (init_done),
    .rd_err_o    (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write, wait (bounded) for its grant, release after the commit edge
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    bit got = 0;
    wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (wr_gnt) got = 1;
      tick();
    end
    wr_req = 1'b0;
    chk("wr_grant_seen", 64'(got), 64'd1);
  endtask

  // Present a read, wait for its grant, then check the beat at grant+RDL
  task automatic do_read(input string tag, input logic [AW-1:0] a,
                         input logic [DW-1:0] exp, input logic exp_err);
    bit got = 0;
    rd_req = 1'b1; rd_addr = a;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (rd_gnt) got = 1;
      tick();
    end
    rd_req = 1'b0;
    chk({tag, "_grant"}, 64'(got), 64'd1);
    for (int i = 1; i < RDL; i++) begin
      @(negedge clk);
      chk({tag, "_early_valid"}, 64'(rd_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
    chk({tag, "_data"}, 64'(rd_data), 64'(exp));
    chk({tag, "_err"}, 64'(rd_err), 64'(exp_err));
    tick();
  endtask

  logic [DW-1:0] exp4 [8];
  int rd_cnt, wr_cnt, waited;

  initial begin
    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;

    // ---- 1: reset, zero-fill, first read returns zero ----
    rd_req = 1'b1; rd_addr = 6'd5;
    tick(); tick();
    @(negedge clk);
    chk("rst_rd_gnt", 64'(rd_gnt), 64'd0);
    chk("rst_wr_gnt", 64'(wr_gnt), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_rd_err", 64'(rd_err), 64'd0);
    tick();
    rst_n = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (rd_gnt || init_done) rd_cnt++;
      tick();
    end
    chk("init_no_gnt", 64'(rd_cnt), 64'd0);
    @(negedge clk);
    chk("init_done_rise", 64'(init_done), 64'd1);
    chk("t1_rd_gnt", 64'(rd_gnt), 64'd1);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("t1_valid_lat1", 64'(rd_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_valid", 64'(rd_valid), 64'd1);
    chk("t1_data", 64'(rd_data), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_single_pulse", 64'(rd_valid), 64'd0);
    chk("t1_data_hold", 64'(rd_data), 64'd0);
    tick();

    // ---- 2: full write, partial byte overwrite, read-after-write ----
    do_write(6'd3, 32'hDEADBEEF, 4'b1111);
    do_write(6'd3, 32'h000000AA, 4'b0001);
    do_read("t2", 6'd3, 32'hDEADBEAA, 1'b0);
    do_write(6'd3, 32'hFFFFFFFF, 4'b0000);
    do_read("t2_be0", 6'd3, 32'hDEADBEAA, 1'b0);

    // ---- 3: contested requests alternate, reads first ----
    rd_req = 1'b1; rd_addr = 6'd10;
    wr_req = 1'b1; wr_addr = 6'd20; wr_data = 32'h11111111; wr_be = 4'b1111;
    rd_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_rd_gnt", 64'(rd_gnt), 64'((i % 2) == 0));
      chk("t3_wr_gnt", 64'(wr_gnt), 64'((i % 2) == 1));
      if (rd_gnt) rd_cnt++;
      if (wr_gnt) wr_cnt++;
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    chk("t3_rd_count", 64'(rd_cnt), 64'd3);
    chk("t3_wr_count", 64'(wr_cnt), 64'd3);
    tick(); tick(); tick();
    do_read("t3_wr_data", 6'd20, 32'h11111111, 1'b0);

    // ---- 4: eight back-to-back reads stream back in order ----
    for (int i = 0; i < 8; i++) begin
      exp4[i] = 32'hC0DE0000 | 32'(i * 17 + 1);
      do_write(6'(i), exp4[i], 4'b1111);
    end
    tick(); tick();
    for (int c = 0; c < 8 + RDL; c++) begin
      rd_req  = (c < 8);
      rd_addr = 6'(c % 8);
      @(negedge clk);
      if (c < 8) chk("t4_gnt", 64'(rd_gnt), 64'd1);
      if (c >= RDL) begin
        chk("t4_valid", 64'(rd_valid), 64'd1);
        chk("t4_data", 64'(rd_data), 64'(exp4[c-RDL]));
      end else begin
        chk("t4_no_valid", 64'(rd_valid), 64'd0);
      end
      tick();
    end
    rd_req = 1'b0;
    @(negedge clk);
    chk("t4_stream_end", 64'(rd_valid), 64'd0);
    chk("t4_data_hold", 64'(rd_data), 64'(exp4[7]));
    tick();

    // ---- 5: reset with reads in flight ----
    rd_req = 1'b1; rd_addr = 6'd3;
    @(negedge clk);
    chk("t5_gnt_a", 64'(rd_gnt), 64'd1);
    tick();
    rd_addr = 6'd4;
    @(negedge clk);
    chk("t5_gnt_b", 64'(rd_gnt), 64'd1);
    tick();
    rd_req = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("t5_gnt_in_rst", 64'(rd_gnt), 64'd0);
    tick();
    rst_n = 1'b1;
    rd_cnt = 0;
    waited = 0;
    while (!init_done && waited < DEPTH + 10) begin
      @(negedge clk);
      if (rd_valid) rd_cnt++;
      if (!init_done) waited++;
      tick();
    end
    chk("t5_no_valid_after_rst", 64'(rd_cnt), 64'd0);
    chk("t5_reinit_cycles", 64'(waited), 64'(DEPTH));
    do_read("t5_cleared", 6'd3, 32'h0, 1'b0);

`ifdef MANNIX_BANK_PARITY_EN
    // ---- 6: corrupted stored bit flagged; clean word not flagged ----
    do_write(6'd9, 32'h12345678, 4'b1111);
    tick();
    dut.mem_q[9] = dut.mem_q[9] ^ 32'h00000100;
    do_read("t6_bad", 6'd9, 32'h12345778, 1'b1);
    do_write(6'd4, 32'h0F0F0F0F, 4'b1111);
    do_read("t6_clean", 6'd4, 32'h0F0F0F0F, 1'b0);
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mannix_mem_bank_rsp
`default_nettype wire
